clock_gate_controller: RTL

- Generates the active-low clock-enable that drives the compute-domain glitchless clock buffer.
- Runs on the free-running control clock.
- Merges per-core stall requests and host start/stop commands into one enable. Allows a programmable pipeline-drain delay before gating, a minimum off-time, and a wake settling delay.
- Keeps a saturating counter of gated cycles for the performance-counter readout.

---
 rtl/clock_ctrl_pkg.sv | 31 +++
 rtl/sat_counter.sv | 26 ++
 rtl/clock_gate_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the compute-domain clock gate controller.
//   - ctrl_state_e : FSM state encodings exposed on the debug state port
//   - Def*         : default parameter values
//   - timer_width  : width of the shared down-counter for a given parameter set
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StDrain   = 2'd1,
    StStopped = 2'd2,
    StWake    = 2'd3
  } ctrl_state_e;

  localparam int unsigned DefNumStall    = 4;
  localparam int unsigned DefDrainCycles = 3;
  localparam int unsigned DefMinOff      = 2;
  localparam int unsigned DefWakeCycles  = 2;
  localparam int unsigned DefCountW      = 32;

  // Bits needed to hold the largest timer load, never less than one.
  function automatic int unsigned timer_width(input int unsigned drain, input int unsigned min_off,
                                              input int unsigned wake);
    int unsigned m;
    m = drain;
    if (min_off > m) m = min_off;
    if (wake > m) m = wake;
    if (m == 0) return 1;
    return (m == 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
//   clock, reset_n : control clock, async active-low reset (count -> 0)
//   clear          : synchronous clear, wins over incr
//   incr           : count one event this cycle
//   count          : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_gate_controller.sv
// Produces the registered active-low clock enable for the compute-domain clock buffer.
//   clock, reset_n : free-running control clock, async active-low reset
//   stall_req      : level stall requests, any bit high requests a stop
//   host_stop      : pulse, sets the sticky host hold
//   host_start     : pulse, clears the sticky host hold (host_stop wins on collision)
//   count_clear    : synchronous clear of gated_cycles
//   ce_n           : registered enable, 0 = clock runs, 1 = gated
//   halted         : high while STOPPED
//   state_o        : current FSM state for debug
//   gated_cycles   : saturating count of cycles with ce_n high
module clock_gate_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STALL      = DefNumStall,
  parameter int unsigned DRAIN_CYCLES   = DefDrainCycles,
  parameter int unsigned MIN_OFF_CYCLES = DefMinOff,
  parameter int unsigned WAKE_CYCLES    = DefWakeCycles,
  parameter int unsigned COUNT_W        = DefCountW
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_STALL-1:0] stall_req,
  input  logic                 host_stop,
  input  logic                 host_start,
  input  logic                 count_clear,
  output logic                 ce_n,
  output logic                 halted,
  output logic [1:0]           state_o,
  output logic [COUNT_W-1:0]   gated_cycles
);

  localparam int unsigned TW = timer_width(DRAIN_CYCLES, MIN_OFF_CYCLES, WAKE_CYCLES);

  // Loads are guarded so a zero parameter never underflows; those paths are bypassed anyway.
  localparam logic [TW-1:0] DrainLoad = TW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [TW-1:0] OffLoad   = TW'((MIN_OFF_CYCLES > 0) ? MIN_OFF_CYCLES - 1 : 0);
  localparam logic [TW-1:0] WakeLoad  = TW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
  // Coming out of reset the off time is one cycle longer than after a normal stop.
  localparam logic [TW-1:0] ResetLoad = TW'(MIN_OFF_CYCLES);

  ctrl_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic          host_hold_q;
  logic          req;

  // Hold uses its registered value, so a host pulse affects req one cycle later.
  assign req = (|stall_req) | host_hold_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      host_hold_q <= 1'b1;
    end else if (host_stop) begin
      host_hold_q <= 1'b1;
    end else if (host_start) begin
      host_hold_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StStopped;
      timer_q <= ResetLoad;
      ce_n    <= 1'b1;
      halted  <= 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (req) begin
            if (DRAIN_CYCLES > 0) begin
              state_q <= StDrain;
              timer_q <= DrainLoad;
            end else begin
              state_q <= StStopped;
              timer_q <= OffLoad;
              ce_n    <= 1'b1;
              halted  <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (!req) begin
            state_q <= StRun;
          end else if (timer_q == '0) begin
            state_q <= StStopped;
            timer_q <= OffLoad;
            ce_n    <= 1'b1;
            halted  <= 1'b1;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        StStopped: begin
          // Requests are ignored until the minimum off time has run out.
          if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end else if (!req) begin
            halted <= 1'b0;
            if (WAKE_CYCLES > 0) begin
              state_q <= StWake;
              timer_q <= WakeLoad;
            end else begin
              state_q <= StRun;
              ce_n    <= 1'b0;
            end
          end
        end
        StWake: begin
          if (req) begin
            state_q <= StStopped;
            timer_q <= OffLoad;
            halted  <= 1'b1;
          end else if (timer_q == '0) begin
            state_q <= StRun;
            ce_n    <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= StStopped;
          timer_q <= OffLoad;
          ce_n    <= 1'b1;
          halted  <= 1'b1;
        end
      endcase
    end
  end

  assign state_o = state_q;

  sat_counter #(
    .WIDTH (COUNT_W)
  ) u_gated_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (count_clear),
    .incr    (ce_n),
    .count   (gated_cycles)
  );

endmodule
